obuf_act_quant: RTL and testbench

- Output-buffer post-processing stage, directly downstream of the per-tile layer/tile settings register.
- Consumes PE partial sums, one lane per beat, plus the registered tile configuration.
- Either passes accumulated partial sums through unchanged (intermediate input-channel pass), or applies quantisation shift, ReLU/Leaky activation and saturation to WORD_SIZE (final input-channel pass).
- Tracks element position within the tile and flags the last output beat.

---
 rtl/obuf_act_quant_if.sv | 33 +++
 rtl/obuf_act_quant.sv | 178 +++++++++++++++++
 tb/tb_obuf_act_quant.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obuf_act_quant_if.sv
// ---------------------------------------------------------------------------
// obuf_act_quant_if
// Stream bundle for the output-buffer post-processing stage.
//   in_valid / in_ready      : input beat handshake
//   psum_in / psum_prev      : signed PE partial sum and stored partial sum
//   out_valid / out_ready    : output beat handshake
//   out_data                 : result word (ACC_SIZE wide)
//   out_last                 : last element of the current tile
// Modports: master = producer/consumer side (testbench or surrounding
// datapath), slave = the obuf_act_quant stage itself.
// ---------------------------------------------------------------------------
interface obuf_act_quant_if #(
    parameter int ACC_SIZE = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [ACC_SIZE-1:0] psum_in;
    logic [ACC_SIZE-1:0] psum_prev;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_SIZE-1:0] out_data;
    logic                out_last;

    modport master (
        output in_valid, psum_in, psum_prev, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, psum_in, psum_prev, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/obuf_act_quant.sv
// ---------------------------------------------------------------------------
// obuf_act_quant
// Output-buffer post-processing: accumulate PE partial sums, and on the final
// input-channel pass apply quantisation shift, ReLU / Leaky ReLU and
// saturation to WORD_SIZE. Three-stage pipeline with a single global enable,
// plus an element counter that flags the last beat of a tile.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   have_accu                : add psum_prev to psum_in
//   have_last_ich            : final pass, enables quantise/activate path
//   have_relu, have_leaky    : activation enable / leaky select
//   quant_pe                 : arithmetic right shift after accumulate
//   quant_activation         : right shift after the leaky multiply
//   quant_next_layer         : right shift before saturation
//   leaky_constant           : signed leaky multiplier
//   obuf_tile_size_x/_y      : tile dimensions in elements
//   bus (slave)              : in/out stream handshake and data
//   tile_done                : one-cycle pulse after the last beat leaves
//
// Build option: OBUF_ROUND_EN - when defined, the final shift rounds half-up.
// ---------------------------------------------------------------------------
module obuf_act_quant #(
    parameter int WORD_SIZE      = 16,
    parameter int ACC_SIZE       = 32,
    parameter int HALF_ADDR_SIZE = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      have_accu,
    input  logic                      have_last_ich,
    input  logic                      have_relu,
    input  logic                      have_leaky,
    input  logic [5:0]                quant_pe,
    input  logic [5:0]                quant_activation,
    input  logic [5:0]                quant_next_layer,
    input  logic [WORD_SIZE-1:0]      leaky_constant,
    input  logic [HALF_ADDR_SIZE-1:0] obuf_tile_size_x,
    input  logic [HALF_ADDR_SIZE-1:0] obuf_tile_size_y,
    obuf_act_quant_if.slave           bus,
    output logic                      tile_done
);
    localparam int CNT_W = 2 * HALF_ADDR_SIZE;
    localparam int Y_W   = ACC_SIZE + 1;
    localparam logic signed [Y_W-1:0] SAT_MAX = Y_W'((2 ** (WORD_SIZE - 1)) - 1);
    localparam logic signed [Y_W-1:0] SAT_MIN = -Y_W'(2 ** (WORD_SIZE - 1));

    logic                       s1_valid_q, s1_valid_d;
    logic                       s1_fin_q, s1_fin_d;
    logic signed [ACC_SIZE-1:0] s1_sum_q, s1_sum_d;
    logic                       s2_valid_q, s2_valid_d;
    logic                       s2_fin_q, s2_fin_d;
    logic signed [ACC_SIZE-1:0] s2_val_q, s2_val_d;
    logic                       out_valid_q, out_valid_d;
    logic        [ACC_SIZE-1:0] out_data_q, out_data_d;
    logic        [CNT_W-1:0]    cnt_q, cnt_d;
    logic                       tile_done_q, tile_done_d;

    logic                       en;
    logic                       fire;
    logic                       last;
    logic        [CNT_W-1:0]    total;
    logic signed [ACC_SIZE-1:0] lc_ext;
    logic signed [ACC_SIZE-1:0] x_pe;
    logic signed [ACC_SIZE-1:0] prod;
    logic signed [ACC_SIZE-1:0] x_act;
    logic signed [ACC_SIZE-1:0] s2_calc;
    logic signed [Y_W-1:0]      y_in;
    logic signed [Y_W-1:0]      y_sh;
    logic        [ACC_SIZE-1:0] y_sat;
`ifdef OBUF_ROUND_EN
    localparam logic [5:0] QNL_MAX = 6'(ACC_SIZE);
    logic signed [Y_W-1:0]      bias;
    logic signed [Y_W-1:0]      y_sum;
`endif

    always_comb begin
        en    = !out_valid_q || bus.out_ready;
        fire  = out_valid_q && bus.out_ready;
        total = CNT_W'(obuf_tile_size_x) * CNT_W'(obuf_tile_size_y);
        // total == 0 never matches, so an empty tile never raises out_last
        last  = out_valid_q && (total != '0) && (cnt_q == total - CNT_W'(1));

        // S2 datapath. The low ACC_SIZE bits of the full-width leaky product
        // equal the ACC_SIZE-wide product, so the multiply is formed there.
        lc_ext = {{(ACC_SIZE - WORD_SIZE){leaky_constant[WORD_SIZE-1]}}, leaky_constant};
        x_pe   = s1_sum_q >>> quant_pe;
        prod   = x_pe * lc_ext;
        x_act  = prod >>> quant_activation;
        s2_calc = s1_sum_q;
        if (s1_fin_q) begin
            s2_calc = x_pe;
            if (have_relu && x_pe[ACC_SIZE-1]) begin
                s2_calc = have_leaky ? x_act : '0;
            end
        end

        // S3 datapath, one guard bit so the rounding bias cannot overflow
        y_in = {s2_val_q[ACC_SIZE-1], s2_val_q};
`ifdef OBUF_ROUND_EN
        bias = '0;
        if ((quant_next_layer != 6'd0) && (quant_next_layer <= QNL_MAX)) begin
            bias = Y_W'(1) <<< (quant_next_layer - 6'd1);
        end
        y_sum = y_in + bias;
        // beyond ACC_SIZE the rounded quotient of any ACC_SIZE value is 0
        y_sh  = (quant_next_layer > QNL_MAX) ? '0 : (y_sum >>> quant_next_layer);
`else
        y_sh = y_in >>> quant_next_layer;
`endif
        if (y_sh > SAT_MAX) begin
            y_sat = ACC_SIZE'(SAT_MAX);
        end else if (y_sh < SAT_MIN) begin
            y_sat = ACC_SIZE'(SAT_MIN);
        end else begin
            y_sat = ACC_SIZE'(y_sh);
        end

        s1_valid_d  = s1_valid_q;
        s1_fin_d    = s1_fin_q;
        s1_sum_d    = s1_sum_q;
        s2_valid_d  = s2_valid_q;
        s2_fin_d    = s2_fin_q;
        s2_val_d    = s2_val_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (en) begin
            s1_valid_d  = bus.in_valid;
            s1_fin_d    = have_last_ich;
            s1_sum_d    = have_accu ? ($signed(bus.psum_in) + $signed(bus.psum_prev))
                                    : $signed(bus.psum_in);
            s2_valid_d  = s1_valid_q;
            s2_fin_d    = s1_fin_q;
            s2_val_d    = s2_calc;
            out_valid_d = s2_valid_q;
            out_data_d  = s2_fin_q ? y_sat : s2_val_q;
        end

        cnt_d       = cnt_q;
        tile_done_d = fire && last;
        if (fire) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_fin_q    <= 1'b0;
            s1_sum_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_fin_q    <= 1'b0;
            s2_val_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            tile_done_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fin_q    <= s1_fin_d;
            s1_sum_q    <= s1_sum_d;
            s2_valid_q  <= s2_valid_d;
            s2_fin_q    <= s2_fin_d;
            s2_val_q    <= s2_val_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
            tile_done_q <= tile_done_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = last;
    assign tile_done     = tile_done_q;

endmodule

// File: tb/tb_obuf_act_quant.sv
// ---------------------------------------------------------------------------
// tb_obuf_act_quant
// Directed cases for the documented corner values, then randomized tiles with
// random backpressure compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_obuf_act_quant;
    localparam int WORD_SIZE      = 16;
    localparam int ACC_SIZE       = 32;
    localparam int HALF_ADDR_SIZE = 6;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      have_accu = 1'b0;
    logic                      have_last_ich = 1'b0;
    logic                      have_relu = 1'b0;
    logic                      have_leaky = 1'b0;
    logic [5:0]                quant_pe = '0;
    logic [5:0]                quant_activation = '0;
    logic [5:0]                quant_next_layer = '0;
    logic [WORD_SIZE-1:0]      leaky_constant = '0;
    logic [HALF_ADDR_SIZE-1:0] tile_x = 6'd1;
    logic [HALF_ADDR_SIZE-1:0] tile_y = 6'd1;
    logic                      tile_done;

    obuf_act_quant_if #(.ACC_SIZE(ACC_SIZE)) bus ();

    obuf_act_quant #(
        .WORD_SIZE(WORD_SIZE),
        .ACC_SIZE(ACC_SIZE),
        .HALF_ADDR_SIZE(HALF_ADDR_SIZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .have_accu(have_accu),
        .have_last_ich(have_last_ich),
        .have_relu(have_relu),
        .have_leaky(have_leaky),
        .quant_pe(quant_pe),
        .quant_activation(quant_activation),
        .quant_next_layer(quant_next_layer),
        .leaky_constant(leaky_constant),
        .obuf_tile_size_x(tile_x),
        .obuf_tile_size_y(tile_y),
        .bus(bus),
        .tile_done(tile_done)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint exp_q[$];
    int     mcnt    = 0;
    logic   td_pend = 1'b0;
    logic   ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    // floor(v / 2^s)
    function automatic longint fdiv2(input longint v, input int s);
        longint d;
        int     sc;
        sc = (s > 62) ? 62 : s;
        d  = longint'(1) << sc;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic longint wrap32(input longint v);
        int t;
        t = int'(v[31:0]);
        return longint'(t);
    endfunction

    function automatic longint model(input longint a, input longint b);
        longint sum, x, y;
        longint lim;
        sum = have_accu ? wrap32(a + b) : a;
        if (!have_last_ich) return sum;
        x = fdiv2(sum, int'(quant_pe));
        if (have_relu && x < 0) begin
            if (have_leaky)
                x = fdiv2(wrap32(x * longint'($signed(leaky_constant))), int'(quant_activation));
            else
                x = 0;
        end
`ifdef OBUF_ROUND_EN
        if (quant_next_layer == 0)
            y = x;
        else if (quant_next_layer >= 40)
            y = 0;
        else
            y = fdiv2(x + (longint'(1) << (int'(quant_next_layer) - 1)), int'(quant_next_layer));
`else
        y = fdiv2(x, int'(quant_next_layer));
`endif
        lim = longint'(1) << (WORD_SIZE - 1);
        if (y > lim - 1) y = lim - 1;
        if (y < -lim) y = -lim;
        return y;
    endfunction

    function automatic logic [31:0] rand_psum();
        if ($urandom_range(0, 1) == 0)
            return 32'($urandom_range(0, 4000)) - 32'd2000;
        return 32'($urandom);
    endfunction

    task automatic set_cfg(input logic accu, input logic fin, input logic relu, input logic leaky,
                           input int qpe, input int qa, input int qnl, input int lc,
                           input int tx, input int ty);
        have_accu        = accu;
        have_last_ich    = fin;
        have_relu        = relu;
        have_leaky       = leaky;
        quant_pe         = 6'(qpe);
        quant_activation = 6'(qa);
        quant_next_layer = 6'(qnl);
        leaky_constant   = 16'(lc);
        tile_x           = 6'(tx);
        tile_y           = 6'(ty);
    endtask

    // Called at the negedge, while handshake outputs are stable.
    task automatic observe();
        logic   fire, exp_last;
        int     total;
        longint e;
        check_val("tile_done", tile_done, td_pend);
        check_val("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
        total    = int'(tile_x) * int'(tile_y);
        exp_last = bus.out_valid && (total != 0) && (mcnt == total - 1);
        check_val("out_last", bus.out_last, exp_last);
        fire    = bus.out_valid && bus.out_ready;
        td_pend = fire && exp_last;
        if (fire) begin
            if (exp_q.size() == 0) begin
                check_val("beat_expected", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_val("out_data", $signed(bus.out_data), e);
            end
            mcnt = exp_last ? 0 : (mcnt + 1) % 4096;
        end
    endtask

    task automatic run_tile(input int beats, input bit pattern);
        int sent = 0;
        int cyc  = 0;
        while ((sent < beats || exp_q.size() != 0) && cyc < 2000) begin
            @(posedge clk); #1;
            bus.in_valid  = (sent < beats) && (pattern || $urandom_range(0, 3) != 0);
            bus.psum_in   = rand_psum();
            bus.psum_prev = rand_psum();
            bus.out_ready = pattern ? ready_pat[cyc % 4] : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            observe();
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(longint'($signed(bus.psum_in)), longint'($signed(bus.psum_prev))));
                sent++;
            end
            cyc++;
        end
        check_val("tile_sent", sent, beats);
        check_val("tile_drain", exp_q.size(), 0);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        observe();
    endtask

    // Single beat through an empty pipe on a 1x1 tile.
    task automatic direct(input string tag, input longint a, input longint b, input longint expv);
        int lat;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.psum_in   = a[31:0];
        bus.psum_prev = b[31:0];
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_latency"}, lat, 3);
        check_val(tag, $signed(bus.out_data), expv);
        check_val({tag, "_last"}, bus.out_last, 1);
        @(posedge clk); #1;
        check_val({tag, "_done"}, tile_done, 1);
        check_val({tag, "_drained"}, bus.out_valid, 0);
        @(posedge clk); #1;
        check_val({tag, "_done_once"}, tile_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.psum_in   = '0;
        bus.psum_prev = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_data", bus.out_data, 0);
        check_val("rst_out_last", bus.out_last, 0);
        check_val("rst_tile_done", tile_done, 0);
        check_val("rst_in_ready", bus.in_ready, 1);

        set_cfg(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        direct("partial", 100, -30, 70);
        set_cfg(0, 1, 1, 1, 0, 7, 0, 13, 1, 1);
        direct("leaky_neg", -256, 0, -26);
        direct("leaky_sat", 40000, 0, 32767);
        set_cfg(0, 1, 1, 0, 2, 0, 0, 0, 1, 1);
        direct("relu_neg", -8, 0, 0);
        direct("relu_pos", 20, 0, 5);
        set_cfg(0, 1, 0, 0, 0, 0, 1, 0, 1, 1);
`ifdef OBUF_ROUND_EN
        direct("round", 3, 0, 2);
`else
        direct("round", 3, 0, 1);
`endif

        // 2x3 tile with the 1,0,0,1 ready pattern, then a second tile
        set_cfg(1, 1, 1, 1, 3, 4, 2, 77, 2, 3);
        run_tile(6, 1'b1);
        run_tile(6, 1'b0);

        // reset with two beats in flight, partway into a tile
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 2, 3);
        run_tile(1, 1'b0);
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.psum_in   = 32'd11;
        @(posedge clk); #1;
        bus.psum_in   = 32'd12;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_mid_valid", bus.out_valid, 0);
        check_val("rst_mid_done", tile_done, 0);
        repeat (3) begin
            @(negedge clk);
            check_val("rst_mid_flushed", bus.out_valid, 0);
            check_val("rst_mid_no_done", tile_done, 0);
        end
        exp_q.delete();
        mcnt    = 0;
        td_pend = 1'b0;
        run_tile(6, 1'b0);

        for (int t = 0; t < 16; t++) begin
            set_cfg($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                    $urandom_range(0, 1),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 12),
                    $urandom_range(0, 10),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 6),
                    $urandom_range(0, 65535), $urandom_range(1, 4), $urandom_range(1, 4));
            run_tile(int'(tile_x) * int'(tile_y), 1'b0);
        end

        // empty tile size: stream runs, no out_last, no tile_done
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        run_tile(5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
